// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and the
// multiply/divide unit.
//   start, op, op1, op2, kill : execute stage -> unit
//   busy, done, result        : unit -> execute stage
// master = execute stage side, slave = muldiv_unit side.
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  kill;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (output start, op, op1, op2, kill, input busy, done, result);
  modport slave  (input start, op, op1, op2, kill, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide for the execute stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_unit_if.slave
//     start/op/op1/op2 request (sampled in IDLE only), kill flush,
//     busy (state != IDLE), done (1-cycle pulse), result (held until next accept)
// Multiply is shift-add (1 bit/cycle), divide is restoring (1 bit/cycle),
// both on operand magnitudes with the sign fixed up in the last iteration.
// Divide by zero and signed overflow skip iteration and finish in one cycle.
// Build option: MULDIV_FAST_MUL_EN -- multiplies use one combinational 33x33
// signed multiply at accept and finish in one cycle; divide unchanged.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state, state_nxt;

  // hi/lo: product halves (mul) or remainder/quotient (div); mcand: multiplicand or divisor
  logic [W-1:0]  hi, lo, mcand, result_q;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic          neg_q, neg_r;

  // ---- request decode (used only on accept)
  logic         is_div, sgn1, sgn2, special;
  logic [W-1:0] mag1, mag2, special_res;
  always_comb begin
    is_div = bus.op[2];
    if (is_div) begin
      sgn1 = ~bus.op[0] & bus.op1[W-1];
      sgn2 = ~bus.op[0] & bus.op2[W-1];
    end else begin
      sgn1 = (bus.op[1:0] != 2'b11) & bus.op1[W-1];  // MULHU is the only unsigned-op1 multiply
      sgn2 = ~bus.op[1] & bus.op2[W-1];              // MULHSU/MULHU take op2 unsigned
    end
    mag1 = sgn1 ? -bus.op1 : bus.op1;
    mag2 = sgn2 ? -bus.op2 : bus.op2;
    special     = 1'b0;
    special_res = '0;
    if (is_div) begin
      if (bus.op2 == '0) begin
        special     = 1'b1;
        special_res = bus.op[1] ? bus.op1 : '1;
      end else if (~bus.op[0] && bus.op1 == {1'b1, {(W-1){1'b0}}} && bus.op2 == '1) begin
        special     = 1'b1;
        special_res = bus.op[1] ? '0 : bus.op1;
      end
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [W:0]     fa, fb;
  logic signed [2*W-1:0] fprod;
  logic [W-1:0]          fast_res;
  always_comb begin
    fa       = {sgn1, bus.op1};  // sgn1 already folds in signedness of the op
    fb       = {sgn2, bus.op2};
    fprod    = fa * fb;
    fast_res = (bus.op[1:0] == 2'b00) ? fprod[W-1:0] : fprod[2*W-1:W];
  end
  localparam state_t MUL_ENTRY = S_DONE;
`else
  localparam state_t MUL_ENTRY = S_MUL;
`endif

  // ---- one iteration step + final sign fix-up
  logic [W:0]     mul_sum, div_t, div_diff;
  logic [W-1:0]   step_hi, step_lo, res_fin;
  logic [2*W-1:0] prod, prod_s;
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_t    = {hi, lo[W-1]};
    div_diff = div_t - {1'b0, mcand};  // bit W set = borrow, keep partial remainder
    if (state == S_DIV) begin
      step_hi = div_diff[W] ? div_t[W-1:0] : div_diff[W-1:0];
      step_lo = {lo[W-2:0], ~div_diff[W]};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], lo[W-1:1]};
    end
    prod   = {step_hi, step_lo};
    prod_s = neg_q ? -prod : prod;
    if (state == S_DIV)
      res_fin = op_q[1] ? (neg_r ? -step_hi : step_hi) : (neg_q ? -step_lo : step_lo);
    else
      res_fin = (op_q == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
  end

  logic accept, iterating, last_iter;
  assign accept    = (state == S_IDLE) && bus.start && !bus.kill;
  assign iterating = (state == S_MUL) || (state == S_DIV);
  assign last_iter = (cnt == CW'(W-1));

  // ---- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (accept) state_nxt = is_div ? (special ? S_DONE : S_DIV) : MUL_ENTRY;
      S_MUL, S_DIV: if (bus.kill) state_nxt = S_IDLE;
                    else if (last_iter) state_nxt = S_DONE;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // ---- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0; lo <= '0; mcand <= '0; cnt <= '0;
      op_q <= '0; neg_q <= 1'b0; neg_r <= 1'b0; result_q <= '0;
    end else if (accept) begin
      op_q  <= bus.op[1:0];
      cnt   <= '0;
      hi    <= '0;
      lo    <= is_div ? mag1 : mag2;
      mcand <= is_div ? mag2 : mag1;
      neg_q <= sgn1 ^ sgn2;
      neg_r <= sgn1;
      if (is_div && special) result_q <= special_res;
`ifdef MULDIV_FAST_MUL_EN
      if (!is_div) result_q <= fast_res;
`endif
    end else if (iterating && !bus.kill) begin
      hi  <= step_hi;
      lo  <= step_lo;
      cnt <= cnt + CW'(1);
      if (last_iter) result_q <= res_fin;
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected results are queued when a
// request is issued and popped when done is seen.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    if (op[2]) begin
      if (b == 32'h0) return op[1] ? a : 32'hFFFFFFFF;
      if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : 32'h80000000;
    end
    case (op)
      3'd0:    p = sa * sbv;
      3'd1:    p = sa * sbv;
      3'd2:    p = sa * ub;
      3'd3:    p = ua * ub;
      3'd4:    p = sa / sbv;
      3'd5:    p = ua / ub;
      3'd6:    p = sa % sbv;
      default: p = ua % ub;
    endcase
    if (op == 3'd1 || op == 3'd2 || op == 3'd3) return p[63:32];
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 32'h0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
    return 33;
  endfunction

  // Called at posedge+1 in IDLE; leaves at the edge that accepts the request (+1).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.op1 = a; bus.op2 = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 3'($urandom); bus.op1 = $urandom; bus.op2 = $urandom;  // captured copies must be used
  endtask

  task automatic wait_done(output int lat, output logic [31:0] got);
    lat = 0; got = 'x;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin lat = n; got = bus.result; break; end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv, input int exp_lat);
    int lat; logic [31:0] got, e;
    exp_q.push_back(expv);
    issue(op, a, b);
    wait_done(lat, got);
    total++;
    if (lat == 0) begin
      bad++; $display("FAIL %s timeout: no done within 100 cycles", name);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin bad++; $display("FAIL %s result: got %h want %h", name, got, e); end
      total++;
      if (lat !== exp_lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
      last_res = e;
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL %s after-done: done=%b busy=%b want 0 0", name, bus.done, bus.busy);
      end
    end
    @(posedge clk); #1;
  endtask

  // Counts done pulses over n cycles; returns the count.
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0; bus.op1 = '0; bus.op2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset result: got %h want 0", bus.result); end
    last_res = 32'h0;
  endtask

  task automatic test_mul;
    logic [2:0] op; logic [31:0] a, b;
    run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    run_op("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulhsu_-1", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      run_op("mul_rand", op, a, b, ref_md(op, a, b), MUL_LAT);
    end
  endtask

  task automatic test_div;
    logic [2:0] op; logic [31:0] a, b;
    run_op("div_-7/2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem_-7/2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu_100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    for (int i = 0; i < 8; i++) begin
      op = 3'(4 + $urandom_range(0, 3)); a = $urandom; b = (i == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
      run_op("div_rand", op, a, b, ref_md(op, a, b), ref_lat(op, a, b));
    end
  endtask

  task automatic test_special;
    run_op("divu_5/0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem_5/0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
  endtask

  task automatic test_busy_ignore;
    int lat, n; logic [31:0] got, e;
    exp_q.push_back(32'd14);
    issue(3'd5, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1 bus.op = 3'd0; bus.op1 = 32'd3; bus.op2 = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(lat, got);
    total++;
    if (lat == 0) begin
      bad++; $display("FAIL busy_ignore timeout: no done");
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin bad++; $display("FAIL busy_ignore result: got %h want %h", got, e); end
      last_res = e;
    end
    count_done(40, n);
    total++; if (n !== 0) begin bad++; $display("FAIL busy_ignore extra done: got %0d want 0", n); end
    total++; if (bus.result !== last_res) begin bad++; $display("FAIL busy_ignore held: got %h want %h", bus.result, last_res); end
  endtask

  task automatic test_kill;
    int n;
    issue(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(posedge clk); #1 bus.kill = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL kill busy: got %b want 0", bus.busy); end
    count_done(40, n);
    total++; if (n !== 0) begin bad++; $display("FAIL kill done: got %0d pulses want 0", n); end
    total++; if (bus.result !== last_res) begin bad++; $display("FAIL kill result: got %h want %h", bus.result, last_res); end
    // kill and start together in IDLE: nothing accepted
    bus.kill = 1'b1; bus.start = 1'b1; bus.op = 3'd5; bus.op1 = 32'd9; bus.op2 = 32'd0;
    @(posedge clk); #1 bus.kill = 1'b0; bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL kill_start busy: got %b want 0", bus.busy); end
    count_done(5, n);
    total++; if (n !== 0) begin bad++; $display("FAIL kill_start done: got %0d pulses want 0", n); end
  endtask

  task automatic test_reset_mid;
    issue(3'd4, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_mid done: got %b want 0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL rst_mid result: got %h want 0", bus.result); end
    last_res = 32'h0;
    run_op("mul_after_rst", 3'd0, 32'd12345, 32'd678, 32'd8369910, MUL_LAT);
  endtask

  task automatic test_back_to_back;
    run_op("b2b_div", 3'd4, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33);
    run_op("b2b_mulhu", 3'd3, 32'h00010000, 32'h00010000, 32'h00000001, MUL_LAT);
    run_op("b2b_remu", 3'd7, 32'hFFFFFFFF, 32'h10, 32'hF, 33);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_busy_ignore();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
